stream_cipher_ctrl: RTL and testbench

STREAM_CIPHER_CTRL -- requirements
Module: stream_cipher_ctrl

---
 rtl/stream_cipher_ctrl.sv | 163 ++++++++++++++++
 tb/tb_stream_cipher_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_cipher_ctrl.sv
// Byte-stream controller for an external cipher datapath: loads plaintext bytes,
// reads stored bytes back (plain or cipher view) oldest-first, and clears the store.
module stream_cipher_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       rd_start,
  input  logic       rd_mode,
  input  logic       clr,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic [7:0] c_data,
  output logic [2:0] c_ct,
  output logic       c_inc,
  output logic       c_encrypt,
  output logic       c_view,
  output logic       c_rst_n,
  input  logic [7:0] c_out,
  output logic       busy,
  output logic [3:0] count,
  output logic [2:0] dbg_state
);

  // Both streams use valid/ready: a byte moves on a rising clk edge where valid
  // and ready are both high; valid and its payload stay stable until then.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_SETUP = 3'd1,
    LD_PULSE = 3'd2,
    LD_HOLD  = 3'd3,
    RD_SETUP = 3'd4,
    RD_OUT   = 3'd5,
    CLR      = 3'd6
  } state_t;

  state_t     state, state_nx;
  logic [2:0] idx, idx_nx;
  logic [3:0] count_nx, count_dec;
  logic [7:0] c_data_nx, m_data_nx;
  logic [2:0] c_ct_nx;
  logic       c_inc_nx, c_encrypt_nx, c_view_nx;
  logic       m_valid_nx, m_last_nx;
  logic       clr_cnt, clr_cnt_nx;

  assign s_ready   = (state == IDLE) & ~clr & ~rd_start;
  assign busy      = (state != IDLE);
  assign c_rst_n   = rst_n & (state != CLR);
  assign dbg_state = state;
  assign count_dec = count - 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= 4'd0;
      idx       <= 3'd0;
      c_data    <= 8'd0;
      c_ct      <= 3'd0;
      c_inc     <= 1'b0;
      c_encrypt <= 1'b0;
      c_view    <= 1'b0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= 8'd0;
      clr_cnt   <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      idx       <= idx_nx;
      c_data    <= c_data_nx;
      c_ct      <= c_ct_nx;
      c_inc     <= c_inc_nx;
      c_encrypt <= c_encrypt_nx;
      c_view    <= c_view_nx;
      m_valid   <= m_valid_nx;
      m_last    <= m_last_nx;
      m_data    <= m_data_nx;
      clr_cnt   <= clr_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    count_nx     = count;
    idx_nx       = idx;
    c_data_nx    = c_data;
    c_ct_nx      = c_ct;
    c_inc_nx     = 1'b0;
    c_encrypt_nx = 1'b0;
    c_view_nx    = c_view;
    m_valid_nx   = m_valid;
    m_last_nx    = m_last;
    m_data_nx    = m_data;
    clr_cnt_nx   = clr_cnt;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nx   = CLR;
          count_nx   = 4'd0;
          clr_cnt_nx = 1'b0;
        end else if (rd_start) begin
          // A readback of an empty store is dropped without leaving IDLE.
          if (count != 4'd0) begin
            state_nx  = RD_SETUP;
            c_view_nx = rd_mode;
            idx_nx    = count_dec[2:0];
            c_ct_nx   = count_dec[2:0];
          end
        end else if (s_valid) begin
          state_nx     = LD_SETUP;
          c_data_nx    = s_data;
          c_encrypt_nx = 1'b1;
        end
      end
      LD_SETUP: begin
        state_nx     = LD_PULSE;
        c_encrypt_nx = 1'b1;
        c_inc_nx     = 1'b1;
      end
      LD_PULSE: begin
        state_nx     = LD_HOLD;
        c_encrypt_nx = 1'b1;
      end
      LD_HOLD: begin
        state_nx = IDLE;
        count_nx = (count == 4'd8) ? count : count + 4'd1;
      end
      RD_SETUP: begin
        // c_ct has been stable for this whole cycle, so c_out has settled.
        state_nx   = RD_OUT;
        m_data_nx  = c_out;
        m_valid_nx = 1'b1;
        m_last_nx  = (idx == 3'd0);
      end
      RD_OUT: begin
        if (m_ready) begin
          m_valid_nx = 1'b0;
          m_last_nx  = 1'b0;
          if (idx == 3'd0) begin
            state_nx = IDLE;
          end else begin
            state_nx = RD_SETUP;
            idx_nx   = idx - 3'd1;
            c_ct_nx  = idx - 3'd1;
          end
        end
      end
      CLR: begin
        if (clr_cnt) begin
          state_nx   = IDLE;
          clr_cnt_nx = 1'b0;
        end else begin
          clr_cnt_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stream_cipher_ctrl.sv
// Directed bench for stream_cipher_ctrl with a behavioural cipher datapath:
// ct byte = new byte XOR previous newest plaintext byte.
module tb_stream_cipher_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'd0;
  logic       rd_start = 1'b0;
  logic       rd_mode = 1'b0;
  logic       clr = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_last;
  logic [7:0] c_data;
  logic [2:0] c_ct;
  logic       c_inc;
  logic       c_encrypt;
  logic       c_view;
  logic       c_rst_n;
  logic [7:0] c_out;
  logic       busy;
  logic [3:0] count;
  logic [2:0] dbg_state;

  stream_cipher_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .rd_start(rd_start), .rd_mode(rd_mode), .clr(clr),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .c_data(c_data), .c_ct(c_ct), .c_inc(c_inc), .c_encrypt(c_encrypt),
    .c_view(c_view), .c_rst_n(c_rst_n), .c_out(c_out),
    .busy(busy), .count(count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Cipher datapath model: index 0 holds the newest byte.
  logic [7:0] mpt [8];
  logic [7:0] mct [8];
  int         n_pulse = 0;

  always @(posedge c_inc or negedge c_rst_n) begin
    if (!c_rst_n) begin
      for (int i = 0; i < 8; i++) begin
        mpt[i] <= 8'd0;
        mct[i] <= 8'd0;
      end
    end else if (c_encrypt) begin
      for (int i = 7; i > 0; i--) begin
        mpt[i] <= mpt[i-1];
        mct[i] <= mct[i-1];
      end
      mpt[0] <= c_data;
      mct[0] <= c_data ^ mpt[0];
    end
  end

  always @(posedge c_inc) n_pulse <= n_pulse + 1;

  always_comb c_out = c_view ? mct[c_ct] : mpt[c_ct];

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 0; rd_start = 0; clr = 0; m_ready = 0;
    rst_n = 0;
    step();
    chk("rst_state", dbg_state, 3'd0);
    chk("rst_count", count, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_c_inc", c_inc, 1'b0);
    chk("rst_c_encrypt", c_encrypt, 1'b0);
    chk("rst_c_rst_n", c_rst_n, 1'b0);
    chk("rst_c_data", c_data, 8'd0);
    chk("rst_c_ct", c_ct, 3'd0);
    rst_n = 1;
    step();
    chk("rst_rel_c_rst_n", c_rst_n, 1'b1);
    hist.delete();
  endtask

  task automatic load(input logic [7:0] b);
    int p0;
    p0 = n_pulse;
    s_valid = 1; s_data = b;
    #1;
    chk("ld_s_ready", s_ready, 1'b1);
    step();
    s_valid = 0; s_data = ~b;
    chk("ld_setup_enc", c_encrypt, 1'b1);
    chk("ld_setup_inc", c_inc, 1'b0);
    chk("ld_setup_data", c_data, b);
    step();
    chk("ld_pulse_inc", c_inc, 1'b1);
    chk("ld_pulse_data", c_data, b);
    step();
    chk("ld_hold_inc", c_inc, 1'b0);
    chk("ld_hold_enc", c_encrypt, 1'b1);
    chk("ld_hold_data", c_data, b);
    step();
    chk("ld_done_busy", busy, 1'b0);
    chk("ld_done_enc", c_encrypt, 1'b0);
    chk("ld_pulses", n_pulse - p0, 1);
    hist.push_back(b);
  endtask

  task automatic readback(input logic mode, input int stall);
    logic [7:0] exp_q[$];
    logic [7:0] e;
    logic [7:0] prev;
    logic [3:0] cnt0;
    int n, j, t;
    n = (hist.size() > 8) ? 8 : hist.size();
    for (int k = 0; k < n; k++) begin
      j = hist.size() - n + k;
      prev = (j > 0) ? hist[j-1] : 8'd0;
      exp_q.push_back(mode ? (hist[j] ^ prev) : hist[j]);
    end
    cnt0 = count;
    rd_start = 1; rd_mode = mode;
    #1;
    chk("rd_s_ready", s_ready, 1'b0);
    step();
    rd_start = 0;
    chk("rd_c_encrypt", c_encrypt, 1'b0);
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (!m_valid && t < 20) begin
        step();
        t++;
      end
      chk("rd_wait_valid", (t < 20), 1'b1);
      if (t >= 20) return;
      e = exp_q.pop_front();
      chk("rd_m_data", m_data, e);
      chk("rd_c_ct", c_ct, n - 1 - k);
      chk("rd_m_last", m_last, (k == n - 1));
      chk("rd_c_view", c_view, mode);
      if (k == 0) begin
        for (int s = 0; s < stall; s++) begin
          step();
          chk("stall_m_valid", m_valid, 1'b1);
          chk("stall_m_data", m_data, e);
          chk("stall_m_last", m_last, (n == 1));
          chk("stall_c_ct", c_ct, n - 1);
        end
      end
      m_ready = 1;
      step();
      m_ready = 0;
      chk("rd_m_valid_drop", m_valid, 1'b0);
    end
    chk("rd_done_busy", busy, 1'b0);
    chk("rd_count_kept", count, cnt0);
  endtask

  typedef struct {
    logic       clr;
    logic       rd;
    logic       sv;
    logic [7:0] d;
    logic       exp_rdy;
    logic       exp_busy;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int t;
    int p0;
    tbl[0] = '{clr:0, rd:1, sv:0, d:8'h00, exp_rdy:0, exp_busy:0, exp_cnt:4'd0};
    tbl[1] = '{clr:0, rd:0, sv:1, d:8'h41, exp_rdy:1, exp_busy:1, exp_cnt:4'd1};
    tbl[2] = '{clr:0, rd:0, sv:1, d:8'h42, exp_rdy:1, exp_busy:1, exp_cnt:4'd2};
    tbl[3] = '{clr:0, rd:1, sv:1, d:8'h55, exp_rdy:0, exp_busy:1, exp_cnt:4'd2};
    tbl[4] = '{clr:1, rd:1, sv:1, d:8'h66, exp_rdy:0, exp_busy:1, exp_cnt:4'd0};
    tbl[5] = '{clr:0, rd:0, sv:0, d:8'h00, exp_rdy:1, exp_busy:0, exp_cnt:4'd0};

    #2;
    do_reset();

    for (int i = 0; i < 6; i++) begin
      clr = tbl[i].clr; rd_start = tbl[i].rd; s_valid = tbl[i].sv; s_data = tbl[i].d;
      rd_mode = 0;
      #1;
      chk("tbl_s_ready", s_ready, tbl[i].exp_rdy);
      step();
      clr = 0; rd_start = 0; s_valid = 0;
      chk("tbl_busy", busy, tbl[i].exp_busy);
      m_ready = 1;
      t = 0;
      while (busy && t < 50) begin
        step();
        t++;
      end
      m_ready = 0;
      chk("tbl_drain", (t < 50), 1'b1);
      chk("tbl_count", count, tbl[i].exp_cnt);
    end

    // Two loads, then plaintext and ciphertext readbacks.
    do_reset();
    p0 = n_pulse;
    load(8'h41);
    load(8'h42);
    chk("two_pulses", n_pulse - p0, 2);
    chk("two_count", count, 4'd2);
    readback(1'b0, 0);
    readback(1'b1, 0);

    // clr beats rd_start and s_valid; then an empty readback is ignored.
    clr = 1; rd_start = 1; s_valid = 1; s_data = 8'h99;
    #1;
    chk("clr_s_ready", s_ready, 1'b0);
    step();
    clr = 0; rd_start = 0; s_valid = 0;
    chk("clr_state", dbg_state, 3'd6);
    chk("clr_c_rst_n_1", c_rst_n, 1'b0);
    chk("clr_count", count, 4'd0);
    step();
    chk("clr_c_rst_n_2", c_rst_n, 1'b0);
    step();
    chk("clr_c_rst_n_end", c_rst_n, 1'b1);
    chk("clr_busy_end", busy, 1'b0);
    hist.delete();
    rd_start = 1;
    #1;
    chk("empty_rd_s_ready", s_ready, 1'b0);
    step();
    rd_start = 0;
    chk("empty_rd_busy", busy, 1'b0);
    chk("empty_rd_m_valid", m_valid, 1'b0);

    // Nine loads saturate count; readback of 8 with a 5-cycle stall.
    p0 = n_pulse;
    for (int i = 0; i < 9; i++) load(8'h10 + 8'(i));
    chk("nine_pulses", n_pulse - p0, 9);
    chk("nine_count", count, 4'd8);
    readback(1'b0, 5);

    // Reset while in LD_SETUP aborts the load without a c_inc pulse.
    s_valid = 1; s_data = 8'h77;
    step();
    s_valid = 0;
    chk("abort_in_setup", dbg_state, 3'd1);
    p0 = n_pulse;
    #2;
    rst_n = 0;
    #1;
    chk("abort_c_inc", c_inc, 1'b0);
    chk("abort_count", count, 4'd0);
    step();
    rst_n = 1;
    step();
    step();
    step();
    chk("abort_no_pulse", n_pulse - p0, 0);
    chk("abort_state", dbg_state, 3'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_count_after", count, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
